param_serializer_fsm: RTL and testbench
=======================================

// Module: param_serializer_fsm
// PURPOSE
//  Parametrised N-to-1 serializer built around a 4-state FSM, for the board-level serial test designs.
//  Latches a DATA_W-bit word on start and shifts it out one bit per CLKS_PER_BIT clocks, MSB- or LSB-first.
//  Exposes a ready/done handshake plus debug taps (state, bit index, loaded word) for LEDs and HEX displays.
//  Successor to the fixed 16-bit serializer: width, bit period and bit order are now configurable.
// PARAMETERS
//  DATA_W        16  word width in bits; must be >= 2
//  CLKS_PER_BIT  1   clocks each bit is held on serial_out; must be >= 1
//  CNT_W         $clog2(DATA_W+1)  localparam; width of bit_index
// PORTS
//  clock      in   1       rising-edge clock
//  reset      in   1       asynchronous, active-high reset
//  start      in   1       level request; sampled only in IDLE
//  msb_first  in   1       1 = MSB first, 0 = LSB first; sampled in LOAD
//  data_in    in   DATA_W  word to send; sampled in LOAD
//  ready      out  1       1 when state==IDLE (combinational from state)
//  serial_out out  1       current serial bit; 0 when bit_valid==0
//  bit_valid  out  1       1 while in SHIFT
//  data_sent  out  1       1 throughout DONE
//  bit_index  out  CNT_W   position of the current bit in transmission order; 0 outside SHIFT
//  state_q    out  2       IDLE=2'b00, LOAD=2'b01, SHIFT=2'b10, DONE=2'b11
//  shadow     out  DATA_W  copy of the word captured in LOAD
// BEHAVIOUR
//  Reset (async, immediate): state_q=IDLE, serial_out=0, bit_valid=0, data_sent=0, bit_index=0, shadow=0,
//   prescaler=0. ready=1. An in-flight frame is aborted with no partial data_sent.
//  IDLE: if start==1 at an edge -> LOAD; otherwise stay.
//  LOAD (1 cycle): shadow<=data_in, dir<=msb_first, bit_index<=0, prescaler<=0 -> SHIFT.
//  SHIFT: serial_out = shadow[DATA_W-1-bit_index] if dir==1, else shadow[bit_index].
//   The prescaler counts 0..CLKS_PER_BIT-1. When it wraps, bit_index increments.
//   After the last bit period -> DONE.
//  DONE: data_sent=1, serial_out=0. Stay while start==1 (a held switch never retriggers).
//   -> IDLE on the first edge with start==0.
//  Latency: start seen at edge k -> LOAD at k+1 -> first bit valid after edge k+2.
//   Frame occupies DATA_W*CLKS_PER_BIT SHIFT cycles.
//  start, msb_first and data_in are ignored outside IDLE/LOAD; data_in changes mid-frame do not affect output.
//  bit_index never exceeds the last index; there is no wrap into a second frame.
//  Reset asserted in any state overrides every other event in the same cycle.
// CONFIGURATION
//  SERIALIZER_PARITY_EN defined:
//   - One extra bit period follows the last data bit, carrying even parity (^shadow).
//   - During that period bit_index==DATA_W and bit_valid==1; SHIFT lasts (DATA_W+1)*CLKS_PER_BIT cycles.
//  Not defined: frame is exactly DATA_W bits and no parity logic is synthesised.
// TESTING
//  1 DATA_W=16, CPB=1, reset, data_in=16'hF0A5, msb_first=1, pulse start at edge 0
//    -> serial_out 1111_0000_1010_0101 on cycles 2..17; data_sent=1 from cycle 18.
//  2 Same setup with msb_first=0 -> serial_out 1010_0101_0000_1111; bit_index counts 0..15.
//  3 CLKS_PER_BIT=3, data 16'h8001, MSB first
//    -> each bit held 3 cycles; 1 for cycles 2-4, 0 through cycle 46, 1 for cycles 47-49; DONE at cycle 50.
//  4 Hold start=1 through the frame -> exactly one frame; data_sent stays 1 until start=0,
//    then ready=1 on the next edge.
//  5 Assert reset at bit_index=7 -> same cycle: serial_out=0, bit_valid=0, state_q=0, shadow=0.
//    Release reset and start again -> new frame from bit 0.
//  6 With SERIALIZER_PARITY_EN: 16'h0001 -> 17th bit=1 with bit_index=16; 16'h0003 -> 17th bit=0.

Source files
------------

// File: rtl/param_serializer_fsm.sv
// Parametrised N-to-1 serializer: latches a DATA_W-bit word and shifts it out one bit per
// CLKS_PER_BIT clocks, MSB- or LSB-first. Define SERIALIZER_PARITY_EN to append an even-parity bit.
module param_serializer_fsm #(
    parameter  int DATA_W       = 16,
    parameter  int CLKS_PER_BIT = 1,
    localparam int CNT_W        = $clog2(DATA_W + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              msb_first,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready,
    output logic              serial_out,
    output logic              bit_valid,
    output logic              data_sent,
    output logic [CNT_W-1:0]  bit_index,
    output logic [1:0]        state_q,
    output logic [DATA_W-1:0] shadow
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        SHIFT = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam int PRE_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
`ifdef SERIALIZER_PARITY_EN
    localparam int LAST_IDX = DATA_W;
`else
    localparam int LAST_IDX = DATA_W - 1;
`endif
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(LAST_IDX);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLKS_PER_BIT - 1);

    state_t           state;
    logic             dir;
    logic [PRE_W-1:0] prescaler;

    // Bit at transmission position idx; the loop keeps the select within the word's range.
    function automatic logic pick_bit(input logic [DATA_W-1:0] word,
                                      input logic              msb,
                                      input logic [CNT_W-1:0]  idx);
        logic [CNT_W-1:0] pos;
        logic             b;
        pos = msb ? (CNT_W'(DATA_W - 1) - idx) : idx;
        b   = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (pos == CNT_W'(i)) b = word[i];
        end
`ifdef SERIALIZER_PARITY_EN
        if (idx == CNT_W'(DATA_W)) b = ^word;
`endif
        return b;
    endfunction

    assign ready   = (state == IDLE);
    assign state_q = state;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            dir        <= 1'b0;
            prescaler  <= '0;
            bit_index  <= '0;
            serial_out <= 1'b0;
            bit_valid  <= 1'b0;
            data_sent  <= 1'b0;
            // NOTE: shadow is a visible debug tap, so it is reset rather than left as don't-care.
            shadow     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) state <= LOAD;
                end
                LOAD: begin
                    shadow     <= data_in;
                    dir        <= msb_first;
                    bit_index  <= '0;
                    prescaler  <= '0;
                    serial_out <= pick_bit(data_in, msb_first, '0);
                    bit_valid  <= 1'b1;
                    state      <= SHIFT;
                end
                SHIFT: begin
                    if (prescaler == PRE_LAST) begin
                        prescaler <= '0;
                        if (bit_index == LAST_BIT) begin
                            state      <= DONE;
                            bit_valid  <= 1'b0;
                            serial_out <= 1'b0;
                            bit_index  <= '0;
                            data_sent  <= 1'b1;
                        end else begin
                            bit_index  <= bit_index + 1'b1;
                            serial_out <= pick_bit(shadow, dir, bit_index + 1'b1);
                        end
                    end else begin
                        prescaler <= prescaler + 1'b1;
                    end
                end
                DONE: begin
                    // A held start must not retrigger; wait for it to drop.
                    if (!start) begin
                        state     <= IDLE;
                        data_sent <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_param_serializer_fsm.sv
// Self-checking bench for param_serializer_fsm: two instances (1 and 3 clocks per bit) checked
// cycle by cycle against a frame model built from the word, bit order and optional parity bit.
module tb_param_serializer_fsm;

    localparam int DATA_W = 16;
    localparam int CNT_W  = $clog2(DATA_W + 1);
`ifdef SERIALIZER_PARITY_EN
    localparam int NBITS = DATA_W + 1;
`else
    localparam int NBITS = DATA_W;
`endif

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              start0 = 1'b0;
    logic              start1 = 1'b0;
    logic              msb_first = 1'b0;
    logic [DATA_W-1:0] data_in = '0;

    logic              ready0, serial0, valid0, sent0;
    logic [CNT_W-1:0]  idx0;
    logic [1:0]        st0;
    logic [DATA_W-1:0] sh0;
    logic              ready1, serial1, valid1, sent1;
    logic [CNT_W-1:0]  idx1;
    logic [1:0]        st1;
    logic [DATA_W-1:0] sh1;

    logic              o_ready, o_serial, o_valid, o_sent;
    logic [CNT_W-1:0]  o_idx;
    logic [1:0]        o_state;
    logic [DATA_W-1:0] o_shadow;

    int checks = 0;
    int errors = 0;
    int sel    = 0;

    always #5 clock = ~clock;

    param_serializer_fsm #(.DATA_W(DATA_W), .CLKS_PER_BIT(1)) u_cpb1 (
        .clock(clock), .reset(reset), .start(start0), .msb_first(msb_first), .data_in(data_in),
        .ready(ready0), .serial_out(serial0), .bit_valid(valid0), .data_sent(sent0),
        .bit_index(idx0), .state_q(st0), .shadow(sh0)
    );

    param_serializer_fsm #(.DATA_W(DATA_W), .CLKS_PER_BIT(3)) u_cpb3 (
        .clock(clock), .reset(reset), .start(start1), .msb_first(msb_first), .data_in(data_in),
        .ready(ready1), .serial_out(serial1), .bit_valid(valid1), .data_sent(sent1),
        .bit_index(idx1), .state_q(st1), .shadow(sh1)
    );

    always_comb begin
        o_ready  = (sel == 1) ? ready1  : ready0;
        o_serial = (sel == 1) ? serial1 : serial0;
        o_valid  = (sel == 1) ? valid1  : valid0;
        o_sent   = (sel == 1) ? sent1   : sent0;
        o_idx    = (sel == 1) ? idx1    : idx0;
        o_state  = (sel == 1) ? st1     : st0;
        o_shadow = (sel == 1) ? sh1     : sh0;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s (dut %0d): observed %0h expected %0h", tag, sel, observed, expected);
        end
    endtask

    // Reference: p-th transmitted bit of a frame, straight from the bit-order and parity rules.
    function automatic logic exp_bit(input logic [DATA_W-1:0] word, input logic msb, input int p);
        logic [DATA_W-1:0] tmp;
        if (p >= DATA_W) return ^word;
        tmp = msb ? (word >> (DATA_W - 1 - p)) : (word >> p);
        return tmp[0];
    endfunction

    task automatic set_start(input int which, input logic v);
        if (which == 1) start1 = v;
        else            start0 = v;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".state"}, 32'(o_state), 32'd0);
        check({tag, ".ready"}, 32'(o_ready), 32'd1);
        check({tag, ".sent"},  32'(o_sent),  32'd0);
        check({tag, ".valid"}, 32'(o_valid), 32'd0);
    endtask

    // One frame on DUT `which`; abort_at >= 0 asserts reset at that bit position.
    task automatic run_frame(input int which, input logic [DATA_W-1:0] data, input logic msb,
                             input int cpb, input bit hold, input int abort_at);
        sel = which;
        @(negedge clock);
        data_in   = data;
        msb_first = msb;
        set_start(which, 1'b1);
        @(negedge clock);
        check("load.state", 32'(o_state), 32'd1);
        check("load.ready", 32'(o_ready), 32'd0);
        check("load.valid", 32'(o_valid), 32'd0);
        if (!hold) set_start(which, 1'b0);
        for (int p = 0; p < NBITS; p++) begin
            for (int c = 0; c < cpb; c++) begin
                @(negedge clock);
                check("shift.serial", 32'(o_serial), 32'(exp_bit(data, msb, p)));
                check("shift.valid",  32'(o_valid),  32'd1);
                check("shift.index",  32'(o_idx),    32'(p));
                check("shift.state",  32'(o_state),  32'd2);
                check("shift.sent",   32'(o_sent),   32'd0);
                if (p == 0 && c == 0) check("shift.shadow", 32'(o_shadow), 32'(data));
                data_in   = DATA_W'($urandom);
                msb_first = 1'($urandom);
                if (p == abort_at && c == 0) begin
                    reset = 1'b1;
                    #1;
                    check("abort.state",  32'(o_state),  32'd0);
                    check("abort.serial", 32'(o_serial), 32'd0);
                    check("abort.valid",  32'(o_valid),  32'd0);
                    check("abort.shadow", 32'(o_shadow), 32'd0);
                    check("abort.index",  32'(o_idx),    32'd0);
                    check("abort.sent",   32'(o_sent),   32'd0);
                    check("abort.ready",  32'(o_ready),  32'd1);
                    set_start(which, 1'b0);
                    @(negedge clock);
                    reset = 1'b0;
                    return;
                end
            end
        end
        @(negedge clock);
        check("done.state",  32'(o_state),  32'd3);
        check("done.sent",   32'(o_sent),   32'd1);
        check("done.valid",  32'(o_valid),  32'd0);
        check("done.serial", 32'(o_serial), 32'd0);
        check("done.index",  32'(o_idx),    32'd0);
        check("done.ready",  32'(o_ready),  32'd0);
        if (hold) begin
            repeat (3) begin
                @(negedge clock);
                check("hold.state", 32'(o_state), 32'd3);
                check("hold.sent",  32'(o_sent),  32'd1);
            end
            set_start(which, 1'b0);
        end
        @(negedge clock);
        check_idle("after");
    endtask

    initial begin
        reset = 1'b1;
        repeat (2) @(negedge clock);
        sel = 0;
        check_idle("reset0");
        check("reset0.shadow", 32'(o_shadow), 32'd0);
        check("reset0.index",  32'(o_idx),    32'd0);
        sel = 1;
        check_idle("reset1");
        check("reset1.serial", 32'(o_serial), 32'd0);
        reset = 1'b0;

        run_frame(0, 16'hF0A5, 1'b1, 1, 1'b0, -1);
        run_frame(0, 16'hF0A5, 1'b0, 1, 1'b0, -1);
        run_frame(1, 16'h8001, 1'b1, 3, 1'b0, -1);
        run_frame(0, 16'h5A3C, 1'b1, 1, 1'b1, -1);
        run_frame(1, 16'h1234, 1'b0, 3, 1'b1, -1);
        run_frame(0, 16'hC3C3, 1'b1, 1, 1'b0, 7);
        run_frame(0, 16'h9E17, 1'b1, 1, 1'b0, -1);
`ifdef SERIALIZER_PARITY_EN
        run_frame(0, 16'h0001, 1'b1, 1, 1'b0, -1);
        run_frame(0, 16'h0003, 1'b1, 1, 1'b0, -1);
        run_frame(1, 16'h0007, 1'b0, 3, 1'b0, -1);
`endif
        for (int n = 0; n < 8; n++) begin
            int which;
            which = int'($urandom_range(0, 1));
            run_frame(which, DATA_W'($urandom), 1'($urandom), (which == 1) ? 3 : 1,
                      1'($urandom), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time budget");
        $fatal(1, "watchdog expired");
    end

endmodule
